// File: rtl/bpg_pkg.sv
// Shared types and helpers for the bit population generator.
package bpg_pkg;

    typedef enum logic [1:0] {IDLE_S, GEN_S, DONE_S} state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned width);
        return (cnt > width) ? width : cnt;
    endfunction

endpackage

// File: rtl/bit_population_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; shifts right and folds the poly in when bit 0 falls out.
module lfsr16
    import bpg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : 16'h0000);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= SEED;
        else          state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/bit_population_generator.sv
// Produces a WIDTH-bit word with exactly min(count_i, WIDTH) bits set, one LFSR-driven
// bit decision per clock over a single wrapping sweep of positions.
module bit_population_generator
    import bpg_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic [$clog2(WIDTH):0] count_i,
    input  logic                   count_val_i,
    output logic                   count_ready_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   data_val_o,
    input  logic                   data_ready_i
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = $clog2(WIDTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_e            state_q, state_d;
    logic [CW-1:0]     need_q, need_d;
    logic [CW-1:0]     visited_q, visited_d;
    logic [CW-1:0]     req_q, req_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [CW-1:0]     rem;
    logic              set_bit;
    logic [15:0]       lfsr_w;
    logic              lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .state_o (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w;

    always_comb begin
        state_d   = state_q;
        need_d    = need_q;
        visited_d = visited_q;
        req_d     = req_q;
        pos_d     = pos_q;
        mask_d    = mask_q;
        rem       = WIDTH_C - visited_q;
        set_bit   = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (count_val_i) begin
                    need_d    = CW'(clamp_count(32'(count_i), WIDTH));
                    req_d     = need_d;
                    mask_d    = '0;
                    pos_d     = (32'(lfsr_w[PW-1:0]) >= 32'(WIDTH)) ? '0 : lfsr_w[PW-1:0];
                    visited_d = '0;
                    state_d   = (need_d == '0) ? DONE_S : GEN_S;
                end
            end
            GEN_S: begin
                // Forced set once remaining positions equal remaining bits keeps the count exact.
                set_bit = (need_q != '0) && (lfsr_w[0] || (need_q == rem));
                if (set_bit) begin
                    mask_d[pos_q] = 1'b1;
                    need_d        = need_q - CW'(1);
                end
                pos_d     = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
                visited_d = visited_q + CW'(1);
                if ((need_d == '0) || (visited_q == CW'(WIDTH - 1))) state_d = DONE_S;
            end
            DONE_S: begin
                if (data_ready_i) state_d = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE_S;
            need_q    <= '0;
            visited_q <= '0;
            req_q     <= '0;
            pos_q     <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            need_q    <= need_d;
            visited_q <= visited_d;
            req_q     <= req_d;
            pos_q     <= pos_d;
            mask_q    <= mask_d;
        end
    end

    assign data_o        = mask_q;
    assign data_val_o    = (state_q == DONE_S);
    assign count_ready_o = (state_q == IDLE_S);

    a_popcount : assert property (@(posedge clk_i) disable iff (!arstn_i)
        data_val_o |-> ($countones(data_o) == 32'(req_q)));

endmodule

// File: tb/tb_bit_population_generator.sv
// Random request/stall traffic against a transaction-level model of the generator.
module tb_bit_population_generator;

    localparam int W = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        arstn;
    logic [4:0]  count_i;
    logic        count_val_i;
    logic        count_ready_o;
    logic [15:0] data_o;
    logic        data_val_o;
    logic        data_ready_i;

    int n_chk = 0;
    int n_err = 0;

    bit_population_generator #(.WIDTH(W), .LFSR_SEED(SEED)) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .count_i       (count_i),
        .count_val_i   (count_val_i),
        .count_ready_o (count_ready_o),
        .data_o        (data_o),
        .data_val_o    (data_val_o),
        .data_ready_i  (data_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Whole-request prediction: start position from the LFSR at acceptance, then one
    // LFSR step per visited position; a bit is forced when remaining slots == remaining bits.
    function automatic void predict(input logic [15:0] l0, input int cnt,
                                    output logic [15:0] w, output int g);
        int need;
        int pos;
        logic [15:0] l;
        need = (cnt > W) ? W : cnt;
        pos  = int'(l0[3:0]);
        l    = l0;
        w    = '0;
        g    = 0;
        for (int i = 0; i < W && need > 0; i++) begin
            l = lfsr_next(l);
            g++;
            if (l[0] || need == W - i) begin
                w[pos] = 1'b1;
                need--;
            end
            pos = (pos + 1) % W;
        end
    endfunction

    logic [15:0] m_lfsr;
    logic [15:0] m_word;
    logic [15:0] m_pend;
    bit          m_idle;
    bit          m_val;
    int          m_left;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_lfsr = SEED;
            m_word = '0;
            m_pend = '0;
            m_idle = 1'b1;
            m_val  = 1'b0;
            m_left = 0;
        end else begin
            if (m_idle) begin
                if (count_val_i) begin
                    predict(m_lfsr, int'(count_i), m_pend, m_left);
                    m_idle = 1'b0;
                    if (m_left == 0) begin
                        m_val  = 1'b1;
                        m_word = m_pend;
                    end
                end
            end else if (!m_val) begin
                m_left--;
                if (m_left == 0) begin
                    m_val  = 1'b1;
                    m_word = m_pend;
                end
            end else if (data_ready_i) begin
                m_val  = 1'b0;
                m_idle = 1'b1;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (arstn) begin
            chk("data_val_o", 32'(data_val_o), 32'(m_val));
            chk("count_ready_o", 32'(count_ready_o), 32'(m_idle));
            if (m_idle || m_val) chk("data_o", 32'(data_o), 32'(m_word));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 arstn = 1'b0;
        count_val_i  = 1'b0;
        data_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
    endtask

    task automatic request(input int cnt, input int stall, output logic [15:0] w, output int lat);
        int t;
        @(posedge clk);
        #1 count_i = 5'(cnt);
        count_val_i  = 1'b1;
        data_ready_i = 1'b0;
        t = 0;
        while (!count_ready_o && t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        if (t >= 40) chk("accept_timeout", 32'(t), 32'(0));
        @(posedge clk);
        #1 count_val_i = 1'b0;
        lat = 1;
        while (!data_val_o && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        w = data_o;
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        data_ready_i = 1'b1;
        @(posedge clk);
        #1 data_ready_i = 1'b0;
    endtask

    initial begin
        logic [15:0] w, w0, w1, w2;
        int lat, lat1, lat2, n, t;
        arstn        = 1'b1;
        count_i      = '0;
        count_val_i  = 1'b0;
        data_ready_i = 1'b0;
        #2 arstn = 1'b0;
        #1;
        chk("rst_ready", 32'(count_ready_o), 32'd1);
        chk("rst_val", 32'(data_val_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'h0);
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;

        request(0, 0, w, lat);
        chk("n0_word", 32'(w), 32'h0000);
        chk("n0_lat", 32'(lat), 32'd1);
        request(16, 2, w, lat);
        chk("n16_word", 32'(w), 32'hFFFF);
        chk("n16_lat", 32'(lat), 32'd17);
        request(20, 1, w, lat);
        chk("n20_word", 32'(w), 32'hFFFF);
        chk("n20_lat", 32'(lat), 32'd17);

        for (int k = 0; k <= W; k++) begin
            request(k, int'($urandom_range(0, 3)), w, lat);
            chk("sweep_pop", 32'($countones(w)), 32'(k));
            chk("sweep_lat_le17", 32'(lat <= 17), 32'd1);
        end

        for (int k = 0; k < 200; k++) begin
            n = int'($urandom_range(0, 20));
            request(n, int'($urandom_range(0, 4)), w, lat);
            chk("rand_pop", 32'($countones(w)), 32'((n > W) ? W : n));
            chk("rand_lat_le17", 32'(lat <= 17), 32'd1);
        end

        // Output stalled in DONE with a new count pending the whole time.
        @(posedge clk);
        #1 count_i = 5'd3;
        count_val_i = 1'b1;
        t = 0;
        while (!data_val_o && t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        chk("hold_first_pop", 32'($countones(data_o)), 32'd3);
        w0 = data_o;
        count_i = 5'd5;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("hold_data_stable", 32'(data_o), 32'(w0));
        chk("hold_not_ready", 32'(count_ready_o), 32'd0);
        data_ready_i = 1'b1;
        @(posedge clk);
        #1 data_ready_i = 1'b0;
        chk("hold_back_idle", 32'(count_ready_o), 32'd1);
        chk("hold_val_drop", 32'(data_val_o), 32'd0);
        @(posedge clk);
        #1 count_val_i = 1'b0;
        chk("hold_accepted", 32'(count_ready_o), 32'd0);
        t = 0;
        while (!data_val_o && t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        chk("hold_second_pop", 32'($countones(data_o)), 32'd5);
        data_ready_i = 1'b1;
        @(posedge clk);
        #1 data_ready_i = 1'b0;

        // Reset in the middle of a generation.
        @(posedge clk);
        #1 count_i = 5'd8;
        count_val_i = 1'b1;
        @(posedge clk);
        #1 count_val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("midgen_busy", 32'(count_ready_o), 32'd0);
        arstn = 1'b0;
        #1;
        chk("midrst_val", 32'(data_val_o), 32'd0);
        chk("midrst_ready", 32'(count_ready_o), 32'd1);
        chk("midrst_data", 32'(data_o), 32'h0);
        @(posedge clk);
        #1 arstn = 1'b1;
        request(1, 0, w1, lat1);
        chk("post_rst_pop", 32'($countones(w1)), 32'd1);

        do_reset();
        request(1, 0, w1, lat1);
        do_reset();
        request(1, 0, w2, lat2);
        chk("repeat_word", 32'(w2), 32'(w1));
        chk("repeat_lat", 32'(lat2), 32'(lat1));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
